cache_assoc_ctrl: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate cache tag/state controller.

---
 rtl/cache_assoc_ctrl_pkg.sv | 24 ++
 rtl/cache_lru_sel.sv | 51 +++++
 rtl/cache_assoc_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cache_assoc_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_assoc_ctrl_pkg.sv
// Shared types for the set-associative cache controller: commands, bus actions,
// controller states and the line-address helper.
package cache_assoc_ctrl_pkg;

    typedef enum logic [1:0] {RESET, INVALIDATE, READ, WRITE} inst_t;
    typedef enum logic [1:0] {NOP, READ_OUT, WRITE_OUT, RW_OUT} output_t;
    typedef logic valid_t;
    typedef logic bool_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, FLUSH} ctrl_state_t;

    localparam int LINE_ADDR_MAX_W = 64;

    // Rebuilds a line-aligned byte address from its tag and set index.
    function automatic logic [LINE_ADDR_MAX_W-1:0] line_addr(
        input logic [LINE_ADDR_MAX_W-1:0] tag,
        input logic [LINE_ADDR_MAX_W-1:0] idx,
        input int                         off_w,
        input int                         idx_w
    );
        return (tag << (off_w + idx_w)) | (idx << off_w);
    endfunction

endpackage

// File: rtl/cache_lru_sel.sv
// Combinational true-LRU helper for one set: picks the fill victim and computes
// the ages after touching a way.
module cache_lru_sel
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages,
    input  logic [WAYS-1:0]            valid,
    input  logic [AGE_W-1:0]           hit_way,
    output logic [AGE_W-1:0]           victim_way,
    output logic [WAYS-1:0][AGE_W-1:0] next_ages
);

    valid_t free_found;
    logic [AGE_W-1:0] touched_age;

    // An empty way always beats evicting; otherwise the oldest way goes.
    always_comb begin
        victim_way = '0;
        free_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !free_found) begin
                victim_way = AGE_W'(w);
                free_found = 1'b1;
            end
        end
        if (!free_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[w] == AGE_W'(WAYS - 1)) begin
                    victim_way = AGE_W'(w);
                end
            end
        end
    end

    always_comb begin
        touched_age = ages[hit_way];
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == hit_way) begin
                next_ages[w] = '0;
            end else if (ages[w] < touched_age) begin
                next_ages[w] = ages[w] + 1'b1;
            end else begin
                next_ages[w] = ages[w];
            end
        end
    end

endmodule

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back/write-allocate tag and state controller.
// One command every three cycles; state commits at the end of RESPOND.
module cache_assoc_ctrl
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 6,
    parameter int SETS   = 16,
    parameter int WAYS   = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  inst_t             cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output output_t           resp_bus,
    output logic [ADDR_W-1:0] resp_bus_addr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    ctrl_state_t state;
    inst_t       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    bool_t            hit_q;
    logic [AGE_W-1:0] way_q;
    logic [IDX_W-1:0] flush_idx;

    logic [TAG_W-1:0]            tag_arr   [SETS][WAYS];
    logic [WAYS-1:0]             valid_arr [SETS];
    logic [WAYS-1:0]             dirty_arr [SETS];
    logic [WAYS-1:0][AGE_W-1:0]  age_arr   [SETS];

    bool_t            lk_hit;
    logic [AGE_W-1:0] lk_way;
    output_t          lk_bus;
    logic [ADDR_W-1:0] lk_addr;
    logic [AGE_W-1:0] victim_way;
    logic [WAYS-1:0][AGE_W-1:0] next_ages;
    valid_t           victim_dirty;
    logic [LINE_ADDR_MAX_W-1:0] wb_full;
    logic [LINE_ADDR_MAX_W-1:0] hit_full;
    logic             unused_bits;

    assign unused_bits = ^{cmd_addr[OFF_W-1:0], wb_full[LINE_ADDR_MAX_W-1:ADDR_W],
                           hit_full[LINE_ADDR_MAX_W-1:ADDR_W]};

    cache_lru_sel #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .ages       (age_arr[idx_q]),
        .valid      (valid_arr[idx_q]),
        .hit_way    (way_q),
        .victim_way (victim_way),
        .next_ages  (next_ages)
    );

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q) && !lk_hit) begin
                lk_hit = 1'b1;
                lk_way = AGE_W'(w);
            end
        end
    end

    assign victim_dirty = valid_arr[idx_q][victim_way] && dirty_arr[idx_q][victim_way];
    assign wb_full  = line_addr(LINE_ADDR_MAX_W'(tag_arr[idx_q][victim_way]),
                                LINE_ADDR_MAX_W'(idx_q), OFF_W, IDX_W);
    assign hit_full = line_addr(LINE_ADDR_MAX_W'(tag_q), LINE_ADDR_MAX_W'(idx_q), OFF_W, IDX_W);

    // Bus action only carries an address when a dirty line leaves the cache.
    always_comb begin
        lk_bus  = NOP;
        lk_addr = '0;
        case (op_q)
            READ, WRITE: begin
                if (!lk_hit) begin
                    if (victim_dirty) begin
                        lk_bus  = RW_OUT;
                        lk_addr = wb_full[ADDR_W-1:0];
                    end else begin
                        lk_bus = READ_OUT;
                    end
                end
            end
            INVALIDATE: begin
                if (lk_hit && dirty_arr[idx_q][lk_way]) begin
                    lk_bus  = WRITE_OUT;
                    lk_addr = hit_full[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= READ;
            tag_q         <= '0;
            idx_q         <= '0;
            hit_q         <= 1'b0;
            way_q         <= '0;
            flush_idx     <= '0;
            cmd_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            resp_bus      <= NOP;
            resp_bus_addr <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_arr[s][w] <= '0;
                    age_arr[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        tag_q     <= cmd_addr[ADDR_W-1:OFF_W+IDX_W];
                        idx_q     <= cmd_addr[OFF_W+IDX_W-1:OFF_W];
                        cmd_ready <= 1'b0;
                        flush_idx <= '0;
                        state     <= (cmd_op == RESET) ? FLUSH : LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q         <= lk_hit;
                    way_q         <= lk_hit ? lk_way : victim_way;
                    resp_valid    <= 1'b1;
                    resp_hit      <= lk_hit;
                    resp_bus      <= lk_bus;
                    resp_bus_addr <= lk_addr;
                    state         <= RESPOND;
                end
                RESPOND: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    case (op_q)
                        READ, WRITE: begin
                            age_arr[idx_q] <= next_ages;
                            if (hit_q) begin
                                if (op_q == WRITE) dirty_arr[idx_q][way_q] <= 1'b1;
                                hit_count <= (hit_count == {CNT_W{1'b1}}) ? hit_count
                                                                          : hit_count + CNT_W'(1);
                            end else begin
                                tag_arr[idx_q][way_q]   <= tag_q;
                                valid_arr[idx_q][way_q] <= 1'b1;
                                dirty_arr[idx_q][way_q] <= (op_q == WRITE);
                                miss_count <= (miss_count == {CNT_W{1'b1}}) ? miss_count
                                                                            : miss_count + CNT_W'(1);
                            end
                        end
                        INVALIDATE: begin
                            if (hit_q) begin
                                valid_arr[idx_q][way_q] <= 1'b0;
                                dirty_arr[idx_q][way_q] <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                FLUSH: begin
                    // Dirty data is dropped on purpose: a RESET command discards the cache.
                    valid_arr[flush_idx] <= '0;
                    dirty_arr[flush_idx] <= '0;
                    for (int w = 0; w < WAYS; w++) begin
                        age_arr[flush_idx][w] <= AGE_W'(w);
                    end
                    hit_count  <= '0;
                    miss_count <= '0;
                    if (flush_idx == IDX_W'(SETS - 1)) begin
                        state         <= RESPOND;
                        resp_valid    <= 1'b1;
                        resp_hit      <= 1'b0;
                        resp_bus      <= NOP;
                        resp_bus_addr <= '0;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Randomised bench for cache_assoc_ctrl against a recency-list reference model;
// a second instance with 4-bit counters shares the command stream.
module tb_cache_assoc_ctrl;
    import cache_assoc_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 6;
    localparam int SETS   = 16;
    localparam int WAYS   = 4;
    localparam int IDX_W  = 4;
    localparam int SAT_W  = 4;
    localparam longint SAT_MAX = 15;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid;
    inst_t cmd_op;
    logic [ADDR_W-1:0] cmd_addr;

    logic cmd_ready, resp_valid, resp_hit;
    output_t resp_bus;
    logic [ADDR_W-1:0] resp_bus_addr;
    logic [31:0] hit_count, miss_count;

    logic s_cmd_ready, s_resp_valid, s_resp_hit;
    output_t s_resp_bus;
    logic [ADDR_W-1:0] s_resp_bus_addr;
    logic [SAT_W-1:0] s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    cache_assoc_ctrl #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_bus(resp_bus), .resp_bus_addr(resp_bus_addr),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_assoc_ctrl #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .resp_valid(s_resp_valid), .resp_hit(s_resp_hit),
        .resp_bus(s_resp_bus), .resp_bus_addr(s_resp_bus_addr),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // Reference model: per-set recency list, position 0 = most recently used.
    logic [31:0] m_tag   [SETS][WAYS];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_list  [SETS][WAYS];
    longint      m_hits, m_misses;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_list[s][w]  = w;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void modelTouch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (m_list[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_list[s][i] = m_list[s][i-1];
        m_list[s][0] = w;
    endfunction

    function automatic longint satOf(input longint v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    function automatic void modelStep(input inst_t op, input logic [31:0] addr,
                                      output logic e_hit, output output_t e_bus,
                                      output logic [31:0] e_addr);
        logic [31:0] tag = addr >> (OFF_W + IDX_W);
        int idx = int'((addr >> OFF_W) % SETS);
        int hw = -1;
        int vw = -1;
        e_hit = 1'b0;
        e_bus = NOP;
        e_addr = 32'd0;
        if (op == RESET) begin
            modelReset();
            return;
        end
        for (int w = 0; w < WAYS; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) hw = w;
        if (op == INVALIDATE) begin
            if (hw >= 0) begin
                e_hit = 1'b1;
                if (m_dirty[idx][hw]) begin
                    e_bus  = WRITE_OUT;
                    e_addr = (tag << (OFF_W + IDX_W)) | (32'(idx) << OFF_W);
                end
                m_valid[idx][hw] = 1'b0;
                m_dirty[idx][hw] = 1'b0;
            end
            return;
        end
        if (hw >= 0) begin
            e_hit = 1'b1;
            if (op == WRITE) m_dirty[idx][hw] = 1'b1;
            m_hits++;
            modelTouch(idx, hw);
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[idx][w]) vw = w;
            if (vw < 0) vw = m_list[idx][WAYS-1];
            if (m_valid[idx][vw] && m_dirty[idx][vw]) begin
                e_bus  = RW_OUT;
                e_addr = (m_tag[idx][vw] << (OFF_W + IDX_W)) | (32'(idx) << OFF_W);
            end else begin
                e_bus = READ_OUT;
            end
            m_tag[idx][vw]   = tag;
            m_valid[idx][vw] = 1'b1;
            m_dirty[idx][vw] = (op == WRITE);
            m_misses++;
            modelTouch(idx, vw);
        end
    endfunction

    // cmd_valid stays high with junk while busy; the controller must not pick it up.
    task automatic applyStimulus(input inst_t op, input logic [31:0] addr);
        logic e_hit;
        output_t e_bus;
        logic [31:0] e_addr;
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        modelStep(op, addr, e_hit, e_bus, e_addr);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        @(posedge clk); #1;
        cmd_op   = WRITE;
        cmd_addr = $urandom;
        n = 0;
        while (!resp_valid && n < SETS + 4) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        checkOutput("resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("latency", 64'(n), (op == RESET) ? 64'(SETS) : 64'd1);
        checkOutput("resp_hit", 64'(resp_hit), 64'(e_hit));
        checkOutput("resp_bus", 64'(resp_bus), 64'(e_bus));
        checkOutput("resp_bus_addr", 64'(resp_bus_addr), 64'(e_addr));
        checkOutput("sat_resp_hit", 64'(s_resp_hit), 64'(e_hit));
        @(posedge clk); #1;
        checkOutput("resp_valid_drop", 64'(resp_valid), 64'd0);
        checkOutput("resp_bus_hold", 64'(resp_bus), 64'(e_bus));
        checkOutput("cmd_ready_back", 64'(cmd_ready), 64'd1);
        checkOutput("hit_count", 64'(hit_count), 64'(m_hits));
        checkOutput("miss_count", 64'(miss_count), 64'(m_misses));
        checkOutput("sat_hit_count", 64'(s_hit_count), 64'(satOf(m_hits)));
        checkOutput("sat_miss_count", 64'(s_miss_count), 64'(satOf(m_misses)));
    endtask

    task automatic resetDuringRespond(input logic [31:0] addr);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = READ;
        cmd_addr  = addr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!resp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_resp_seen", 64'(resp_valid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("abort_miss_count", 64'(miss_count), 64'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int r;
        inst_t op;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = READ;
        cmd_addr  = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_hit", 64'(resp_hit), 64'd0);
        checkOutput("rst_resp_bus", 64'(resp_bus), 64'(NOP));
        checkOutput("rst_resp_bus_addr", 64'(resp_bus_addr), 64'd0);
        checkOutput("rst_hit_count", 64'(hit_count), 64'd0);
        checkOutput("rst_miss_count", 64'(miss_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(READ, 32'h0000_1040);
        applyStimulus(READ, 32'h0000_1040);
        applyStimulus(WRITE, 32'h0000_1040);
        applyStimulus(READ, 32'h0000_2040);
        applyStimulus(READ, 32'h0000_3040);
        applyStimulus(READ, 32'h0000_4040);
        applyStimulus(READ, 32'h0000_5040);
        checkOutput("evict_dirty_bus", 64'(resp_bus), 64'(RW_OUT));
        checkOutput("evict_dirty_addr", 64'(resp_bus_addr), 64'h0000_1040);
        applyStimulus(WRITE, 32'h0000_1080);
        applyStimulus(INVALIDATE, 32'h0000_1080);
        applyStimulus(INVALIDATE, 32'h0000_1080);
        applyStimulus(RESET, 32'h0);
        applyStimulus(READ, 32'h0000_1040);

        // Small tag/index pool keeps sets full so evictions and LRU order matter.
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(1, 8) << (OFF_W + IDX_W)) | ($urandom_range(0, 3) << OFF_W)
                | $urandom_range(0, 63);
            r = $urandom_range(0, 49);
            if (r == 0)      op = RESET;
            else if (r < 12) op = INVALIDATE;
            else if (r < 31) op = READ;
            else             op = WRITE;
            applyStimulus(op, a);
        end

        applyStimulus(RESET, 32'h0);
        applyStimulus(READ, 32'h0000_1040);
        for (int i = 0; i < 17; i++) applyStimulus(READ, 32'h0000_1040);
        checkOutput("sat_hit_final", 64'(s_hit_count), 64'd15);

        resetDuringRespond(32'h0000_1040);
        applyStimulus(READ, 32'h0000_1040);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
